led_pwm_bank: RTL

- Memory-mapped LED output peripheral for the priRV32 core; parametrised successor of the core's single `led` output.
- Drives NUM_CH LED channels. Each channel has an independent mode: off, on, PWM dimming, or blink.
- Sits on the core's simple peripheral bus; register reads and writes complete with a fixed one-cycle handshake.

---
 rtl/led_pwm_pkg.sv | 18 +
 rtl/led_channel.sv | 83 ++++++++
 rtl/led_pwm_bank.sv | 110 +++++++++++
 3 files changed

// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM bank: channel modes, register offsets and field positions.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_PWM   = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_e;

    localparam int unsigned PRESC_OFS   = 32'h00;
    localparam int unsigned PERIODS_OFS = 32'h04;
    localparam int unsigned CH_BASE     = 32'h10;

    localparam int unsigned DUTY_LSB = 8;
    localparam int unsigned HALF_LSB = 16;

endpackage

// File: rtl/led_channel.sv
// One LED channel: MODE/DUTY/HALF configuration, blink phase tracking and raw output.
module led_channel
    import led_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en_i,
    input  logic [31:0]         wdata_i,
    input  logic                wrap_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic [31:0]         rdata_o,
    output logic                raw_o
);

    led_mode_e           mode_q, mode_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [15:0]         half_q, half_d;
    logic [15:0]         bcnt_q, bcnt_d;
    logic                phase_q, phase_d;
    logic [15:0]         half_eff;
    logic                unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_comb begin
        mode_d   = mode_q;
        duty_d   = duty_q;
        half_d   = half_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        half_eff = (half_q == 16'd0) ? 16'd1 : half_q;
        // A write restarts the blink sequence and takes priority over a coincident wrap.
        if (wr_en_i) begin
            mode_d  = led_mode_e'(wdata_i[1:0]);
            duty_d  = wdata_i[DUTY_LSB +: PWM_BITS];
            half_d  = wdata_i[HALF_LSB +: 16];
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (wrap_i) begin
            if ({1'b0, bcnt_q} + 17'd1 >= {1'b0, half_eff}) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        unique case (mode_q)
            LED_OFF:   raw_o = 1'b0;
            LED_ON:    raw_o = 1'b1;
            LED_PWM:   raw_o = (pwm_cnt_i < duty_q);
            LED_BLINK: raw_o = phase_q;
        endcase
    end

    always_comb begin
        rdata_o                        = '0;
        rdata_o[1:0]                   = mode_q;
        rdata_o[DUTY_LSB +: PWM_BITS]  = duty_q;
        rdata_o[HALF_LSB +: 16]        = half_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= LED_OFF;
            duty_q  <= '0;
            half_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            duty_q  <= duty_d;
            half_q  <= half_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Memory-mapped LED bank: bus decode, shared prescaler/PWM counter, period count, LED register.
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PRESC_BITS = 16,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ready,
    output logic [NUM_CH-1:0] led
);

    localparam int unsigned AW = ADDR_W - 2;

    logic [AW-1:0]         word;
    logic                  wr, rd, unused_addr;
    logic                  tick, wrap;
    logic [PRESC_BITS-1:0] presc_q, presc_d, presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [31:0]           periods_q, periods_d;
    logic [31:0]           rdata_q, rdata_d, rd_val;
    logic                  ready_q, ready_d;
    logic [NUM_CH-1:0]     led_q, raw, ch_wr;
    logic [31:0]           ch_rdata [NUM_CH];

    assign word        = bus_addr[ADDR_W-1:2];
    assign unused_addr = ^bus_addr[1:0];
    assign wr          = bus_sel & bus_we;
    assign rd          = bus_sel & ~bus_we;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr[i] = wr && (word == AW'(CH_BASE / 4 + i));

        led_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (ch_wr[i]),
            .wdata_i   (bus_wdata),
            .wrap_i    (wrap),
            .pwm_cnt_i (pwm_cnt_q),
            .rdata_o   (ch_rdata[i]),
            .raw_o     (raw[i])
        );
    end

    always_comb begin
        rd_val = '0;
        if (word == AW'(PRESC_OFS / 4)) begin
            rd_val = 32'(presc_q);
        end else if (word == AW'(PERIODS_OFS / 4)) begin
            rd_val = periods_q;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (word == AW'(CH_BASE / 4 + i)) begin
                rd_val = ch_rdata[i];
            end
        end
    end

    always_comb begin
        tick        = (presc_cnt_q == presc_q);
        wrap        = tick & (&pwm_cnt_q);
        presc_d     = presc_q;
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        periods_d   = wrap ? periods_q + 32'd1 : periods_q;
        // Clearing the count on a PRESC write avoids a full-width wrap when PRESC is lowered.
        if (wr && (word == AW'(PRESC_OFS / 4))) begin
            presc_d     = bus_wdata[PRESC_BITS-1:0];
            presc_cnt_d = '0;
        end
        rdata_d = rd ? rd_val : rdata_q;
        ready_d = bus_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            periods_q   <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            led_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            periods_q   <= periods_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            led_q       <= raw;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;
    assign led       = led_q;

endmodule
